// File: rtl/nn_classify_sequencer.sv
// Sequencer that owns the classification core: loads weights, streams one sample,
// runs the core, reads the four scores and returns the signed-argmax class.
module nn_classify_sequencer #(
  parameter int NUM_XWORDS  = 9,
  parameter int NUM_WWORDS  = 10,
  parameter int NUM_OUT     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       load_w,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [63:0]                w_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [63:0]                s_data,
  output logic                       c_valid,
  input  logic                       c_ready,
  output logic [$clog2(NUM_OUT)-1:0] c_class,
  output logic [15:0]                c_score,
  output logic                       w_loaded,
  output logic                       err,
  input  logic                       core_ready,
  output logic                       core_start,
  input  logic                       core_done,
  output logic                       xij_ena,
  output logic [7:0]                 xij_wea,
  output logic [3:0]                 xij_addra,
  output logic [63:0]                xij_dina,
  output logic                       wb_ena,
  output logic [7:0]                 wb_wea,
  output logic [3:0]                 wb_addra,
  output logic [63:0]                wb_dina,
  output logic                       xout_enb,
  output logic [3:0]                 xout_addrb,
  input  logic [15:0]                xout_doutb
);

  localparam int CLS_W = $clog2(NUM_OUT);
  localparam int TW    = $clog2(TIMEOUT_CYC);
  localparam logic [3:0]    W_LAST = 4'(NUM_WWORDS - 1);
  localparam logic [3:0]    X_LAST = 4'(NUM_XWORDS - 1);
  localparam logic [3:0]    N_OUT  = 4'(NUM_OUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_X, S_START, S_WAIT, S_READ, S_EMIT
  } state_t;

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [TW-1:0]    timer, timer_n;
  logic             w_loaded_n, err_n;
  logic [15:0]      best_score, best_score_n;
  logic [CLS_W-1:0] best_class, best_class_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      timer      <= '0;
      w_loaded   <= 1'b0;
      err        <= 1'b0;
      best_score <= '0;
      best_class <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      timer      <= timer_n;
      w_loaded   <= w_loaded_n;
      err        <= err_n;
      best_score <= best_score_n;
      best_class <= best_class_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    timer_n      = timer;
    w_loaded_n   = w_loaded;
    err_n        = err;
    best_score_n = best_score;
    best_class_n = best_class;
    w_ready      = 1'b0;
    s_ready      = 1'b0;
    core_start   = 1'b0;
    c_valid      = 1'b0;
    xout_enb     = 1'b0;
    xout_addrb   = '0;
    if (clr) begin
      state_n    = S_IDLE;
      cnt_n      = '0;
      timer_n    = '0;
      w_loaded_n = 1'b0;
      err_n      = 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          cnt_n = '0;
          if (load_w)                   state_n = S_LOAD_W;
          else if (w_loaded && s_valid) state_n = S_LOAD_X;
        end
        S_LOAD_W: begin
          w_ready = 1'b1;
          if (w_valid) begin
            cnt_n = cnt + 4'd1;
            if (cnt == W_LAST) begin
              cnt_n      = '0;
              w_loaded_n = 1'b1;
              state_n    = S_IDLE;
            end
          end
        end
        S_LOAD_X: begin
          s_ready = 1'b1;
          if (s_valid) begin
            cnt_n = cnt + 4'd1;
            if (cnt == X_LAST) begin
              cnt_n   = '0;
              state_n = S_START;
            end
          end
        end
        S_START: begin
          if (core_ready) begin
            core_start = 1'b1;
            timer_n    = '0;
            state_n    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            cnt_n   = '0;
            state_n = S_READ;
          end else if (timer == T_LAST) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        S_READ: begin
          // Address k is issued at cnt=k; its score is on xout_doutb at cnt=k+1.
          cnt_n = cnt + 4'd1;
          if (cnt < N_OUT) begin
            xout_enb   = 1'b1;
            xout_addrb = cnt;
          end
          if (cnt == 4'd1) begin
            best_score_n = xout_doutb;
            best_class_n = '0;
          end else if (cnt > 4'd1 && $signed(xout_doutb) > $signed(best_score)) begin
            best_score_n = xout_doutb;
            best_class_n = CLS_W'(cnt - 4'd1);
          end
          if (cnt == N_OUT) begin
            cnt_n   = '0;
            state_n = S_EMIT;
          end
        end
        S_EMIT: begin
          c_valid = 1'b1;
          if (c_ready) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign c_class   = best_class;
  assign c_score   = best_score;

  assign wb_ena    = w_ready & w_valid;
  assign wb_wea    = {8{wb_ena}};
  assign wb_addra  = wb_ena ? cnt : 4'd0;
  assign wb_dina   = wb_ena ? w_data : 64'd0;

  assign xij_ena   = s_ready & s_valid;
  assign xij_wea   = {8{xij_ena}};
  assign xij_addra = xij_ena ? cnt : 4'd0;
  assign xij_dina  = xij_ena ? s_data : 64'd0;

endmodule

// File: tb/tb_nn_classify_sequencer.sv
// Randomized scoreboard bench for nn_classify_sequencer with a behavioural core/BRAM model.
module tb_nn_classify_sequencer;
  logic clk = 1'b0;
  logic rst_n, en, clr, load_w, w_valid, s_valid, c_ready, core_ready, core_done;
  logic w_ready, s_ready, c_valid, w_loaded, err, core_start, xij_ena, wb_ena, xout_enb;
  logic [63:0] w_data, s_data, xij_dina, wb_dina;
  logic [1:0]  c_class;
  logic [15:0] c_score, xout_doutb;
  logic [7:0]  xij_wea, wb_wea;
  logic [3:0]  xij_addra, wb_addra, xout_addrb;

  int errors = 0, checks = 0;
  int starts = 0, n_samples = 0, xij_writes = 0, wb_writes = 0;
  bit hold_c = 1'b0, started_flag = 1'b0;

  typedef struct packed { logic [1:0] cls; logic [15:0] sc; } res_t;
  typedef struct { int delay; logic [63:0] sc; } core_t;
  res_t         exp_q[$];
  core_t        core_q[$];
  logic [575:0] x_q[$];
  logic [63:0]  wb_mem[16], xij_mem[16];
  logic [15:0]  xout_mem[4];

  always #5 clk = ~clk;

  nn_classify_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load_w(load_w),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_class(c_class), .c_score(c_score),
    .w_loaded(w_loaded), .err(err),
    .core_ready(core_ready), .core_start(core_start), .core_done(core_done),
    .xij_ena(xij_ena), .xij_wea(xij_wea), .xij_addra(xij_addra), .xij_dina(xij_dina),
    .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
    .xout_enb(xout_enb), .xout_addrb(xout_addrb), .xout_doutb(xout_doutb)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: highest signed score, earliest index wins a tie.
  function automatic res_t ref_argmax(input logic [63:0] sc);
    int best;
    res_t r;
    best = -100000;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'($signed(sc[k*16 +: 16])) > best) begin
        best  = int'($signed(sc[k*16 +: 16]));
        r.cls = 2'(k);
        r.sc  = sc[k*16 +: 16];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_scores();
    logic [63:0] s;
    logic [31:0] r;
    logic [15:0] pick[4];
    pick[0] = 16'h8000; pick[1] = 16'h7fff; pick[2] = 16'h0000; pick[3] = 16'h0100;
    for (int k = 0; k < 4; k++) begin
      r = $urandom;
      s[k*16 +: 16] = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : r[15:0];
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (wb_ena)   wb_mem[wb_addra]   <= wb_dina;
    if (xij_ena)  xij_mem[xij_addra] <= xij_dina;
    if (xout_enb) xout_doutb         <= xout_mem[xout_addrb[1:0]];
  end

  // Write-port rules
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wb_ena) begin
          chk("wb_wea", wb_wea, 64'hff);
          wb_writes++;
        end
        if (xij_ena) begin
          chk("xij_wea", xij_wea, 64'hff);
          xij_writes++;
        end
        if (!en) chk("write_while_en0", {62'd0, xij_ena, wb_ena}, 64'd0);
      end
    end
  end

  // Core model: checks xij contents at start, loads scores, answers done after a delay.
  initial begin
    core_t e;
    logic [575:0] xw, got;
    core_ready = 1'b1;
    core_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && core_start) begin
        starts++;
        started_flag = 1'b1;
        if (core_q.size() == 0 || x_q.size() == 0) begin
          chk("core_start_unexpected", 64'd1, 64'd0);
        end else begin
          e  = core_q.pop_front();
          xw = x_q.pop_front();
          for (int k = 0; k < 9; k++) got[k*64 +: 64] = xij_mem[k];
          checks++;
          if (got !== xw) begin
            errors++;
            $display("FAIL xij_contents: got %h expected %h", got, xw);
          end
          for (int k = 0; k < 4; k++) xout_mem[k] = e.sc[k*16 +: 16];
          @(posedge clk); #1;
          core_ready = 1'b0;
          if (e.delay >= 0) begin
            repeat (e.delay) @(posedge clk);
            #1 core_done = 1'b1;
            @(posedge clk);
            #1 core_done = 1'b0;
          end else begin
            repeat (100) @(posedge clk);
          end
          #1 core_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    c_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      c_ready = hold_c ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard monitor, result stability and timeout timing
  initial begin
    res_t e;
    bit pv;
    logic [17:0] pout;
    int wc;
    logic err_q;
    pv = 0; wc = -1; err_q = 1'b0; pout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; wc = -1; err_q = 1'b0;
      end else begin
        if (pv && en) begin
          chk("c_valid_held", {63'd0, c_valid}, 64'd1);
          chk("c_out_held", {46'd0, c_class, c_score}, {46'd0, pout});
        end
        pv   = c_valid && !c_ready && en && !clr;
        pout = {c_class, c_score};
        if (c_valid && c_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("c_class", {62'd0, c_class}, {62'd0, e.cls});
            chk("c_score", {48'd0, c_score}, {48'd0, e.sc});
          end
        end
        if (core_start) wc = 0;
        else if (wc >= 0) wc++;
        if (err && !err_q) chk("timeout_cycles", 64'(wc), 64'd65);
        err_q = err;
      end
    end
  end

  task automatic load_weights(input bit with_sample);
    logic [63:0] w[10];
    int b, xw0, wb0;
    xw0 = xij_writes;
    wb0 = wb_writes;
    load_w = 1'b1;
    if (with_sample) begin
      s_valid = 1'b1;
      s_data  = {$urandom, $urandom};
    end
    b = 0;
    do begin @(negedge clk); b++; end while (!w_ready && b < 300);
    chk("w_ready_up", {63'd0, w_ready}, 64'd1);
    @(posedge clk); #1;
    load_w  = 1'b0;
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      w[k] = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        w_valid = 1'b0;
        @(posedge clk); #1;
      end
      w_valid = 1'b1;
      w_data  = w[k];
      b = 0;
      do begin @(negedge clk); b++; end while (!w_ready && b < 50);
      if (!w_ready) begin
        chk("w_ready_timeout", 64'd0, 64'd1);
        w_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    @(negedge clk);
    chk("w_loaded_set", {63'd0, w_loaded}, 64'd1);
    chk("wb_write_count", 64'(wb_writes - wb0), 64'd10);
    chk("no_xij_during_wload", 64'(xij_writes - xw0), 64'd0);
    for (int k = 0; k < 10; k++) chk($sformatf("wb_mem[%0d]", k), wb_mem[k], w[k]);
  endtask

  task automatic send_sample(input logic [63:0] sc, input int delay, input bit expect_res,
                             input int pause_at);
    logic [575:0] xw;
    core_t c;
    int b;
    for (int k = 0; k < 9; k++) xw[k*64 +: 64] = {$urandom, $urandom};
    c.delay = delay;
    c.sc    = sc;
    x_q.push_back(xw);
    core_q.push_back(c);
    n_samples++;
    if (expect_res) exp_q.push_back(ref_argmax(sc));
    for (int k = 0; k < 9; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = xw[k*64 +: 64];
      b = 0;
      do begin @(negedge clk); b++; end while (!s_ready && b < 400);
      if (!s_ready) begin
        chk("s_ready_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (k == pause_at) begin
        en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("s_ready_en0", {63'd0, s_ready}, 64'd0);
          @(posedge clk); #1;
        end
        en = 1'b1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || !core_ready) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int b;
    res_t r;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; load_w = 1'b0;
    w_valid = 1'b0; s_valid = 1'b0; w_data = '0; s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_c_valid", {63'd0, c_valid}, 64'd0);
    chk("rst_w_loaded", {63'd0, w_loaded}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_readies", {62'd0, s_ready, w_ready}, 64'd0);
    chk("rst_core_start", {63'd0, core_start}, 64'd0);
    chk("rst_ports", {61'd0, wb_ena, xij_ena, xout_enb}, 64'd0);
    chk("rst_result", {46'd0, c_class, c_score}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("s_ready_no_weights", {63'd0, s_ready}, 64'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;

    load_weights(1'b0);

    send_sample(pack4(16'h0010, 16'h0200, 16'h0150, 16'hff00), 3, 1'b1, -1);
    send_sample(pack4(16'h0100, 16'h0100, 16'h8000, 16'h0000), 0, 1'b1, -1);
    send_sample(pack4(16'hfff0, 16'hff00, 16'hfffe, 16'h8000), 5, 1'b1, -1);
    drain();

    // Downstream stall with a second sample waiting
    hold_c = 1'b1;
    send_sample(rand_scores(), 2, 1'b1, -1);
    fork
      send_sample(rand_scores(), 2, 1'b1, -1);
    join_none
    b = 0;
    do begin @(negedge clk); b++; end while (!c_valid && b < 300);
    chk("stall_c_valid", {63'd0, c_valid}, 64'd1);
    r = {c_class, c_score};
    repeat (5) begin
      @(negedge clk);
      chk("stall_held", {45'd0, c_valid, c_class, c_score}, {45'd0, 1'b1, r});
      chk("stall_no_second", {63'd0, s_ready}, 64'd0);
    end
    hold_c = 1'b0;
    wait fork;
    drain();

    // Core never finishes
    send_sample(rand_scores(), -1, 1'b0, -1);
    b = 0;
    do begin @(negedge clk); b++; end while (!err && b < 400);
    chk("timeout_err", {63'd0, err}, 64'd1);
    send_sample(rand_scores(), 1, 1'b1, -1);

    send_sample(rand_scores(), 4, 1'b1, 3);
    drain();

    load_weights(1'b1);
    drain();

    // Clear during WAIT
    started_flag = 1'b0;
    send_sample(rand_scores(), 30, 1'b0, -1);
    b = 0;
    while (!started_flag && b < 400) begin
      @(negedge clk);
      b++;
    end
    chk("clr_run_started", {63'd0, started_flag}, 64'd1);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_w_loaded", {63'd0, w_loaded}, 64'd0);
    chk("clr_err", {63'd0, err}, 64'd0);
    s_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("s_ready_after_clr", {63'd0, s_ready}, 64'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    load_weights(1'b0);

    for (int i = 0; i < 20; i++) send_sample(rand_scores(), $urandom_range(0, 8), 1'b1, -1);
    drain();
    chk("core_start_count", 64'(starts), 64'(n_samples));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
